// File: rtl/fifo_pkt_pkg.sv
// Types and helpers shared by the read-side packet reader and the planned
// write-side packet generator.
package fifo_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PKT_SIZE   = 10;
  localparam int FOLD_W         = 64;

  // One checksum step; the first byte of a packet seeds the accumulator.
  function automatic logic [FOLD_W-1:0] xor_fold(input logic [FOLD_W-1:0] acc,
                                                  input logic [FOLD_W-1:0] data,
                                                  input logic              first);
    return first ? data : (acc ^ data);
  endfunction

endpackage

// File: rtl/fifo_pkt_reader.sv
// Read-domain packet drain: pops the FIFO into a framed valid/ready stream,
// with per-packet XOR checksum, completion counter and underflow abort.
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PKT_SIZE   = DEF_PKT_SIZE,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  EMPTY,
  output logic                  R_INC,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_FIRST,
  output logic                  OUT_LAST,
  output logic                  PKT_DONE,
  output logic [DATA_WIDTH-1:0] PKT_CSUM,
  output logic                  PKT_ERR,
  output logic [CNT_WIDTH-1:0]  PKT_COUNT,
  output logic                  BUSY
);

  localparam int IDX_W = $clog2(PKT_SIZE);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_SIZE - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [TMR_W-1:0]      timer;
  logic [DATA_WIDTH-1:0] acc;
  logic                  pop, abort, idx_last, in_pkt;

  assign idx_last = (idx == IDX_LAST);
  // Starvation only matters once a packet has actually started.
  assign in_pkt   = (state == STREAM) && (idx != '0);
  assign R_INC    = pop;
  assign PKT_DONE = OUT_VALID && OUT_READY && OUT_LAST;
  assign PKT_ERR  = abort;
  assign BUSY     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (EN && !EMPTY) state_nxt = STREAM;
      STREAM: begin
        pop   = !EMPTY && (!OUT_VALID || OUT_READY);
        abort = in_pkt && EMPTY && (timer == TMR_LAST);
        if (pop && idx_last) state_nxt = DRAIN;
        else if (abort)      state_nxt = IDLE;
      end
      DRAIN:   if (PKT_DONE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      idx       <= '0;
      acc       <= '0;
      timer     <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_FIRST <= 1'b0;
      OUT_LAST  <= 1'b0;
    end else begin
      if (pop) begin
        OUT_DATA  <= RD_DATA;
        OUT_VALID <= 1'b1;
        OUT_FIRST <= (idx == '0);
        OUT_LAST  <= idx_last;
        idx       <= idx_last ? '0 : idx + 1'b1;
        acc       <= DATA_WIDTH'(xor_fold(FOLD_W'(acc), FOLD_W'(RD_DATA), idx == '0));
      end else begin
        if (OUT_READY) OUT_VALID <= 1'b0;
        // A byte already in the output register still drains after an abort.
        if (abort) begin
          idx <= '0;
          acc <= '0;
        end
      end
      if (pop || !in_pkt) timer <= '0;
      else if (EMPTY)     timer <= abort ? '0 : timer + 1'b1;
    end
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      PKT_CSUM  <= '0;
      PKT_COUNT <= '0;
    end else if (PKT_DONE) begin
      PKT_CSUM  <= acc;
      PKT_COUNT <= PKT_COUNT + 1'b1;
    end
  end

endmodule
